cu_fsm_mc: RTL

- Next-generation multicycle control unit FSM for the OTTER RV32I core. Successor to the basic fetch/exec/writeback controller.
- Adds a memory ready handshake with configurable wait/timeout, machine interrupt entry, SYSTEM/CSR/MRET decode, illegal-opcode and memory-timeout fault trapping, and a retired-instruction counter.
- Sits between the IR/memory/CSR file and the PC, regfile and memory enables.

---
 rtl/cu_fsm_mc_pkg.sv | 31 +++
 rtl/cu_fsm_mc_watchdog.sv | 32 +++
 rtl/cu_fsm_mc.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cu_fsm_mc_pkg.sv
// Shared types for the OTTER multicycle control unit: opcode and state
// encodings plus the fault codes reported on the fault output.
package otter_cu_pkg;

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OP_IMM = 7'b0010011,
      OPC_OP     = 7'b0110011,
      OPC_SYSTEM = 7'b1110011
   } opcode_t;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_FETCH,
      ST_EXEC,
      ST_WB,
      ST_INTR,
      ST_FAULT
   } state_t;

   localparam logic [1:0] FLT_NONE    = 2'b00;
   localparam logic [1:0] FLT_ILLEGAL = 2'b01;
   localparam logic [1:0] FLT_MEMTO   = 2'b10;

endpackage

// File: rtl/cu_fsm_mc_watchdog.sv
// Memory-wait watchdog: counts stalled cycles and flags the cycle on which
// the MEM_TIMEOUT-th consecutive wait occurs. MEM_TIMEOUT=0 disables it.
module cu_mem_watchdog #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic timeout
);

   generate
      if (MEM_TIMEOUT == 0) begin : g_off
         logic unused;
         assign unused  = ^{clk, rst, clr, en};
         assign timeout = 1'b0;
      end else begin : g_on
         localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
         logic [CW-1:0] cnt;

         always_ff @(posedge clk) begin
            if (rst || clr) cnt <= '0;
            else if (en)    cnt <= cnt + CW'(1);
         end

         // Fires combinationally so the FSM leaves on the Nth wait cycle itself.
         assign timeout = en && (cnt == CW'(MEM_TIMEOUT - 1));
      end
   endgenerate

endmodule

// File: rtl/cu_fsm_mc.sv
// OTTER RV32I multicycle control unit: fetch/exec/writeback sequencing with
// memory handshake, watchdog, interrupt entry, SYSTEM decode and fault trap.
module cu_fsm_mc
   import otter_cu_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned INTR_EN     = 1,
   parameter int unsigned INSTRET_W   = 32
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [6:0]           opcode,
   input  logic [2:0]           func3,
   input  logic                 mem_rdy,
   input  logic                 intr,
   input  logic                 mie,
   output logic                 PCWRITE,
   output logic                 REGWRITE,
   output logic                 memWE2,
   output logic                 memRDEN1,
   output logic                 memRDEN2,
   output logic                 PC_reset,
   output logic                 csr_WE,
   output logic                 int_taken,
   output logic                 mret_exec,
   output logic [1:0]           fault,
   output logic [INSTRET_W-1:0] instret
);

   state_t  ps, ns;
   opcode_t opc;
   logic [1:0] fault_q, fault_nxt;
   logic wait_en, timeout, retire;

   assign opc   = opcode_t'(opcode);
   assign fault = fault_q;

   assign wait_en = !mem_rdy &&
                    ((ps == ST_FETCH) ||
                     ((ps == ST_EXEC) && ((opc == OPC_LOAD) || (opc == OPC_STORE))));

   cu_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
      .clk     (CLK),
      .rst     (RST),
      .clr     (ns != ps),
      .en      (wait_en),
      .timeout (timeout)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         ps      <= ST_INIT;
         fault_q <= FLT_NONE;
         instret <= '0;
      end else begin
         ps      <= ns;
         fault_q <= fault_nxt;
         if (retire) instret <= instret + INSTRET_W'(1);
      end
   end

   always_comb begin
      ns        = ps;
      fault_nxt = fault_q;
      PCWRITE   = 1'b0;
      REGWRITE  = 1'b0;
      memWE2    = 1'b0;
      memRDEN1  = 1'b0;
      memRDEN2  = 1'b0;
      PC_reset  = 1'b0;
      csr_WE    = 1'b0;
      int_taken = 1'b0;
      mret_exec = 1'b0;

      case (ps)
         ST_INIT: begin
            PC_reset = 1'b1;
            ns       = ST_FETCH;
         end
         ST_FETCH: begin
            memRDEN1 = 1'b1;
            if (mem_rdy) ns = ST_EXEC;
            else if (timeout) begin
               ns        = ST_FAULT;
               fault_nxt = FLT_MEMTO;
            end
         end
         ST_EXEC: begin
            ns = ST_FETCH;
            case (opc)
               OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: begin
                  PCWRITE  = 1'b1;
                  REGWRITE = 1'b1;
               end
               OPC_BRANCH: PCWRITE = 1'b1;
               OPC_LOAD: begin
                  memRDEN2 = 1'b1;
                  if (mem_rdy) ns = ST_WB;
                  else if (timeout) begin
                     ns        = ST_FAULT;
                     fault_nxt = FLT_MEMTO;
                  end else ns = ST_EXEC;
               end
               OPC_STORE: begin
                  memWE2 = 1'b1;
                  if (mem_rdy) PCWRITE = 1'b1;
                  else if (timeout) begin
                     ns        = ST_FAULT;
                     fault_nxt = FLT_MEMTO;
                  end else ns = ST_EXEC;
               end
               OPC_SYSTEM: begin
                  if (func3 == 3'b000) begin
                     mret_exec = 1'b1;
                     PCWRITE   = 1'b1;
                  end else if (func3 == 3'b100) begin
                     ns        = ST_FAULT;
                     fault_nxt = FLT_ILLEGAL;
                  end else begin
                     csr_WE   = 1'b1;
                     REGWRITE = 1'b1;
                     PCWRITE  = 1'b1;
                  end
               end
               default: begin
                  ns        = ST_FAULT;
                  fault_nxt = FLT_ILLEGAL;
               end
            endcase
         end
         ST_WB: begin
            PCWRITE  = 1'b1;
            REGWRITE = 1'b1;
            ns       = ST_FETCH;
         end
         ST_INTR: begin
            int_taken = 1'b1;
            PCWRITE   = 1'b1;
            ns        = ST_FETCH;
         end
         ST_FAULT: ns = ST_FAULT;
         default:  ns = ST_INIT;
      endcase

      // Interrupts divert only a retiring EXEC/WB cycle, never a memory wait.
      retire = ((ps == ST_EXEC) || (ps == ST_WB)) && PCWRITE;
      if (retire && (INTR_EN != 0) && intr && mie) ns = ST_INTR;
   end

endmodule
